// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: debug control, decode vector, I/O handshakes and datapath strobes
// exchanged between the instruction sequencer (master) and the CPU datapath (slave).
interface cpu_sequencer_if #(
    parameter int PC_W  = 12,
    parameter int CNT_W = 16
);
    logic             run_i;
    logic             step_i;
    logic             halt_i;
    logic             bp_en_i;
    logic [PC_W-1:0]  bp_addr_i;
    logic [PC_W-1:0]  pc_i;
    logic [6:0]       ctrl_i;
    logic             inp_valid_i;
    logic             inp_ready_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             ir_en_o;
    logic             pc_en_o;
    logic             acc_wen_o;
    logic             mem_ren_o;
    logic             mem_wen_o;
    logic             out_wen_o;
    logic             halted_o;
    logic             bp_hit_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] icount_o;

    modport master (
        input  run_i, step_i, halt_i, bp_en_i, bp_addr_i, pc_i, ctrl_i,
               inp_valid_i, out_ready_i,
        output inp_ready_o, out_valid_o, ir_en_o, pc_en_o, acc_wen_o,
               mem_ren_o, mem_wen_o, out_wen_o, halted_o, bp_hit_o,
               state_o, icount_o
    );

    modport slave (
        output run_i, step_i, halt_i, bp_en_i, bp_addr_i, pc_i, ctrl_i,
               inp_valid_i, out_ready_i,
        input  inp_ready_o, out_valid_o, ir_en_o, pc_en_o, acc_wen_o,
               mem_ren_o, mem_wen_o, out_wen_o, halted_o, bp_hit_o,
               state_o, icount_o
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/EXEC/MEM/IOWAIT/WB phase controller for the accumulator CPU,
// with run/halt/single-step/breakpoint debug control and I/O valid/ready handshakes.
module cpu_sequencer #(
    parameter int PC_W    = 12,
    parameter int CNT_W   = 16,
    parameter int MEM_LAT = 1
) (
    input logic             clk_i,
    input logic             rst_ni,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        HALT   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        IOWAIT = 3'd4,
        WB     = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] icount;
    logic [1:0]       lat_cnt;
    logic             bp_hit, step_q, skip, free_run, io_inp;
    logic             step_rise, bp_stop, no_io;
    logic             dec_inp, dec_out, dec_mr, dec_mw, dec_alu;
    logic             in_xfer, out_xfer;

    // Decode priority: INP > OUT > MR > MW > ALU|IMM > JMP/NOP
    assign no_io   = ~|bus.ctrl_i[6:5];
    assign dec_inp = bus.ctrl_i[5];
    assign dec_out = bus.ctrl_i[6] & ~bus.ctrl_i[5];
    assign dec_mr  = no_io & bus.ctrl_i[3];
    assign dec_mw  = no_io & ~bus.ctrl_i[3] & bus.ctrl_i[4];
    assign dec_alu = no_io & ~|bus.ctrl_i[4:3] & |bus.ctrl_i[1:0];

    assign step_rise = bus.step_i & ~step_q;
    // skip lets the instruction that stopped on a breakpoint execute once on resume
    assign bp_stop   = state == FETCH && bus.bp_en_i && !skip &&
                       PC_W'(bus.pc_i) == PC_W'(bus.bp_addr_i);

    // In IOWAIT the direction comes from the copy taken at EXEC, not the live ctrl_i
    assign in_xfer  = bus.inp_valid_i & ((state == EXEC & dec_inp) | (state == IOWAIT & io_inp));
    assign out_xfer = bus.out_ready_i & ((state == EXEC & dec_out) | (state == IOWAIT & ~io_inp));

    assign bus.ir_en_o     = state == FETCH && !bp_stop;
    assign bus.pc_en_o     = state == WB;
    assign bus.acc_wen_o   = in_xfer | (state == EXEC & dec_alu) | (state == MEM & lat_cnt == 2'd0);
    assign bus.mem_ren_o   = (state == EXEC & dec_mr) | state == MEM;
    assign bus.mem_wen_o   = state == EXEC & dec_mw;
    assign bus.out_wen_o   = out_xfer;
    assign bus.inp_ready_o = (state == EXEC & dec_inp) | (state == IOWAIT & io_inp);
    assign bus.out_valid_o = (state == EXEC & dec_out) | (state == IOWAIT & ~io_inp);
    assign bus.halted_o    = state == HALT;
    assign bus.bp_hit_o    = bp_hit;
    assign bus.state_o     = state;
    assign bus.icount_o    = icount;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= HALT;
            icount   <= '0;
            lat_cnt  <= '0;
            bp_hit   <= 1'b0;
            step_q   <= 1'b0;
            skip     <= 1'b0;
            free_run <= 1'b0;
            io_inp   <= 1'b0;
        end else begin
            step_q <= bus.step_i;
            case (state)
                HALT: if (bus.run_i || step_rise) begin
                    state    <= FETCH;
                    free_run <= bus.run_i;
                    skip     <= 1'b1;
                    bp_hit   <= 1'b0;
                end
                FETCH: begin
                    skip  <= 1'b0;
                    state <= bp_stop ? HALT : EXEC;
                    if (bp_stop) bp_hit <= 1'b1;
                end
                EXEC: begin
                    io_inp  <= dec_inp;
                    lat_cnt <= 2'(MEM_LAT - 1);
                    state   <= (dec_inp | dec_out) ? ((in_xfer | out_xfer) ? WB : IOWAIT)
                                                   : (dec_mr ? MEM : WB);
                end
                MEM: begin
                    lat_cnt <= lat_cnt - 2'd1;
                    if (lat_cnt == 2'd0) state <= WB;
                end
                IOWAIT: if (in_xfer | out_xfer) state <= WB;
                WB: begin
                    icount <= icount + 1'b1;
                    state  <= (free_run && bus.run_i && !bus.halt_i) ? FETCH : HALT;
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction stream for cpu_sequencer; an instruction-level
// model queues per-instruction expectations and a monitor checks each retirement.
module tb_cpu_sequencer;
    localparam int PC_W    = 12;
    localparam int CNT_W   = 4;
    localparam int MEM_LAT = 2;
    localparam logic [2:0] S_HALT = 3'd0, S_FETCH = 3'd1, S_MEM = 3'd3, S_WB = 3'd5;

    typedef struct {
        int cyc;
        int acc;
        int mren;
        int mwen;
        int owen;
        int hs;
        int icnt;
        int after;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ret = 0;

    cpu_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    cpu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .MEM_LAT(MEM_LAT)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Stimulus acts 2 time units after the falling edge; the monitor samples at 4
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_state(input logic [2:0] s);
        for (int i = 0; i < 60 && bus.state_o != s; i++) tick();
        if (bus.state_o != s) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: state %0d, want %0d", bus.state_o, s);
            finish_run();
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        n_ret = 0;
        exp_q.delete();
    endtask

    task automatic check_reset();
        check("rst_state", bus.state_o, S_HALT);
        check("rst_halted", bus.halted_o, 1);
        check("rst_icount", bus.icount_o, 0);
        check("rst_bp_hit", bus.bp_hit_o, 0);
        check("rst_strobes", {bus.ir_en_o, bus.pc_en_o, bus.acc_wen_o, bus.mem_ren_o,
              bus.mem_wen_o, bus.out_wen_o, bus.inp_ready_o, bus.out_valid_o}, 0);
    endtask

    // Called while the DUT is in FETCH; w = IOWAIT cycles before the I/O partner is ready
    task automatic run_instr(input logic [6:0] c, input int w, input bit free, input bit r, input bit hlt);
        exp_t  e;
        string kind;
        if (c[5]) kind = "inp";
        else if (c[6]) kind = "out";
        else if (c[3]) kind = "mr";
        else if (c[4]) kind = "mw";
        else if (c[1] || c[0]) kind = "alu";
        else kind = "nop";
        e.cyc   = 3 + (kind == "mr" ? MEM_LAT : (kind == "inp" || kind == "out") ? w : 0);
        e.acc   = (kind == "inp" || kind == "mr" || kind == "alu") ? 1 : 0;
        e.mren  = kind == "mr" ? 1 + MEM_LAT : 0;
        e.mwen  = kind == "mw" ? 1 : 0;
        e.owen  = kind == "out" ? 1 : 0;
        e.hs    = (kind == "inp" || kind == "out") ? 1 + w : 0;
        e.icnt  = n_ret % (1 << CNT_W);
        e.after = (free && r && !hlt) ? S_FETCH : S_HALT;
        n_ret++;
        exp_q.push_back(e);
        bus.ctrl_i = c;
        bus.run_i = r;
        bus.inp_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        if (kind == "inp" || kind == "out") begin
            tick();
            if (hlt) bus.halt_i = 1'b1;
            repeat (w) tick();
            bus.inp_valid_i = 1'b1;
            bus.out_ready_i = 1'b1;
        end
        wait_state(S_WB);
        bus.pc_i = bus.pc_i + 1'b1;
        tick();
        bus.inp_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.halt_i = 1'b0;
        if (e.after == S_HALT) bus.run_i = 1'b0;
    endtask

    initial begin
        exp_t cur;
        bit   active, post;
        int   cyc, acc, mren, mwen, owen, hs;
        active = 0;
        post = 0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_ni) begin
                active = 0;
                post = 0;
            end else begin
                if (post) begin
                    post = 0;
                    check("next_state", bus.state_o, cur.after);
                end
                if (bus.ir_en_o) begin
                    active = 1;
                    {cyc, acc, mren, mwen, owen, hs} = '0;
                end
                if (active) begin
                    cyc++;
                    acc  += int'(bus.acc_wen_o);
                    mren += int'(bus.mem_ren_o);
                    mwen += int'(bus.mem_wen_o);
                    owen += int'(bus.out_wen_o);
                    hs   += int'(bus.inp_ready_o | bus.out_valid_o);
                end
                if (active && bus.pc_en_o) begin
                    active = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_retire: got retire, want none");
                    end else begin
                        cur = exp_q.pop_front();
                        post = 1;
                        check("cycles", cyc, cur.cyc);
                        check("acc_wen", acc, cur.acc);
                        check("mem_ren", mren, cur.mren);
                        check("mem_wen", mwen, cur.mwen);
                        check("out_wen", owen, cur.owen);
                        check("handshake", hs, cur.hs);
                        check("icount", bus.icount_o, cur.icnt);
                    end
                end
            end
        end
    end

    initial begin
        int acc_seen, mren_seen;
        logic [6:0] c;
        bus.run_i = 1'b0;
        bus.step_i = 1'b0;
        bus.halt_i = 1'b0;
        bus.bp_en_i = 1'b0;
        bus.bp_addr_i = '0;
        bus.pc_i = '0;
        bus.ctrl_i = '0;
        bus.inp_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        do_reset();
        check_reset();

        bus.run_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            wait_state(S_FETCH);
            c = 7'($urandom);
            if ($urandom_range(0, 1) == 1) c[6:5] = 2'b00;
            run_instr(c, $urandom_range(0, 3), 1, i != 29, 0);
        end
        check("icount_wrap", bus.icount_o, 30 % (1 << CNT_W));

        bus.run_i = 1'b1;
        wait_state(S_FETCH);
        run_instr(7'b0100000, 4, 1, 0, 0);
        bus.run_i = 1'b1;
        wait_state(S_FETCH);
        run_instr(7'b1000000, 3, 1, 1, 1);
        check("halt_in_iowait", bus.halted_o, 1);
        check("halt_icount", bus.icount_o, 32 % (1 << CNT_W));

        bus.pc_i = 12'h00E;
        bus.bp_en_i = 1'b1;
        bus.bp_addr_i = 12'h010;
        bus.run_i = 1'b1;
        wait_state(S_FETCH);
        run_instr(7'b0000010, 0, 1, 1, 0);
        run_instr(7'b0010000, 0, 1, 1, 0);
        check("bp_ir_en", bus.ir_en_o, 0);
        bus.run_i = 1'b0;
        tick();
        check("bp_halted", bus.halted_o, 1);
        check("bp_hit_set", bus.bp_hit_o, 1);
        bus.step_i = 1'b1;
        wait_state(S_FETCH);
        run_instr(7'b0000001, 0, 0, 0, 0);
        check("bp_hit_clr", bus.bp_hit_o, 0);
        repeat (3) tick();
        check("held_step", bus.state_o, S_HALT);
        bus.step_i = 1'b0;
        bus.bp_en_i = 1'b0;
        tick();

        bus.run_i = 1'b1;
        bus.step_i = 1'b1;
        wait_state(S_FETCH);
        run_instr(7'b0000100, 0, 1, 1, 0);
        run_instr(7'b0000000, 0, 1, 0, 0);
        bus.step_i = 1'b0;
        tick();

        bus.run_i = 1'b1;
        wait_state(S_FETCH);
        bus.ctrl_i = 7'b0001000;
        acc_seen = int'(bus.acc_wen_o);
        mren_seen = int'(bus.mem_ren_o);
        tick();
        acc_seen += int'(bus.acc_wen_o);
        mren_seen += int'(bus.mem_ren_o);
        tick();
        check("mr_in_mem", bus.state_o, S_MEM);
        acc_seen += int'(bus.acc_wen_o);
        mren_seen += int'(bus.mem_ren_o);
        rst_ni = 1'b0;
        bus.run_i = 1'b0;
        tick();
        check("mr_rst_state", bus.state_o, S_HALT);
        check("mr_rst_mem_ren", bus.mem_ren_o, 0);
        check("mr_rst_acc_wen", acc_seen, 0);
        check("mr_rst_ren_cycles", mren_seen, 2);
        do_reset();
        check_reset();
        check("queue_empty", exp_q.size(), 0);
        finish_run();
    end
endmodule
